// File: rtl/energy_window_governor.sv
// energy_window_governor: closed-loop DVFS governor.
// Samples the accumulator's running energy total over fixed windows and
// compares each window's energy with hi/lo budgets, using hysteresis.
// It steps through an operating-level table and asks the PLL for the new
// frequency with a req/ack handshake. freq_mhz is the committed frequency
// that feeds the accumulator's current_freq_mhz input.
// Optional build macro: GOV_STATS_EN enables the throttle/boost
// statistics counters. When it is undefined, those ports are tied to 0.
module energy_window_governor #(
  parameter int                        WINDOW_CYCLES = 1024,
  parameter int                        NUM_LEVELS    = 4,
  parameter logic [16*NUM_LEVELS-1:0]  FREQ_TABLE    = {16'd400, 16'd250, 16'd200, 16'd100},
  parameter int                        RESET_LEVEL   = 3,
  parameter int                        HYST_WINDOWS  = 2,
  parameter int                        ACK_TIMEOUT   = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [63:0]                   total_energy_pj,
  input  logic [31:0]                   budget_hi_pj,
  input  logic [31:0]                   budget_lo_pj,
  output logic                          pll_req,
  output logic [15:0]                   pll_freq_mhz,
  input  logic                          pll_ack,
  output logic [15:0]                   freq_mhz,
  output logic [$clog2(NUM_LEVELS)-1:0] level,
  output logic [31:0]                   window_energy_pj,
  output logic                          window_valid,
  output logic                          over_budget,
  output logic                          timeout_err,
  input  logic                          err_clr,
  output logic [15:0]                   throttle_cnt,
  output logic [15:0]                   boost_cnt
);

  localparam int LW = $clog2(NUM_LEVELS);
  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam int SW = $clog2(HYST_WINDOWS + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, REQ} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   win_cnt_q;
  logic [63:0]     base_q;
  logic [SW-1:0]   hi_streak_q, lo_streak_q, hi_streak_d, lo_streak_d;
  logic [LW-1:0]   target_q, target_d;
  logic [TW-1:0]   tmo_cnt_q;

  logic            win_close;
  logic [63:0]     delta;
  logic [31:0]     delta_sat;
  logic            eval, over_w, under_w;
  logic            req_down, req_up, start_req;
  logic            ack_take, timeout_hit;

  function automatic logic [15:0] freq_of(input logic [LW-1:0] l);
    return FREQ_TABLE[int'(l)*16 +: 16];
  endfunction

  // Window close detection and the saturated modular delta for that window
  always_comb begin
    win_close = (state_q != IDLE) && enable && (win_cnt_q == CW'(WINDOW_CYCLES - 1));
    delta     = total_energy_pj - base_q;
    delta_sat = (|delta[63:32]) ? 32'hFFFF_FFFF : delta[31:0];
  end

  // Streak evaluation of the reported window and level-change decision
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    hi_streak_d = hi_streak_q;
    lo_streak_d = lo_streak_q;
    target_d    = level;
    eval        = (state_q == RUN) && enable && window_valid;
    over_w      = window_energy_pj > budget_hi_pj;
    under_w     = window_energy_pj < budget_lo_pj;
    if (over_w) begin
      hi_streak_d = (hi_streak_q == SW'(HYST_WINDOWS)) ? hi_streak_q : hi_streak_q + 1'b1;
      lo_streak_d = '0;
    end else if (under_w) begin
      lo_streak_d = (lo_streak_q == SW'(HYST_WINDOWS)) ? lo_streak_q : lo_streak_q + 1'b1;
      hi_streak_d = '0;
    end else begin
      hi_streak_d = '0;
      lo_streak_d = '0;
    end
    req_down  = eval && over_w && (hi_streak_d >= SW'(HYST_WINDOWS)) && (level != '0);
    req_up    = eval && !over_w && under_w && (lo_streak_d >= SW'(HYST_WINDOWS)) &&
                (level != LW'(NUM_LEVELS - 1));
    start_req = req_down || req_up;
    if (req_down)    target_d = level - 1'b1;
    else if (req_up) target_d = level + 1'b1;
  end

  // Next-state logic for the IDLE/RUN/REQ controller
  always_comb begin
    state_d     = state_q;
    ack_take    = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN: begin
        if (!enable)        state_d = IDLE;
        else if (start_req) state_d = REQ;
      end
      REQ: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (pll_ack) begin
          ack_take = 1'b1;
          state_d  = RUN;
        end else if (tmo_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Window counter, base snapshot and per-window reporting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_cnt_q        <= '0;
      base_q           <= '0;
      window_energy_pj <= '0;
      window_valid     <= 1'b0;
      over_budget      <= 1'b0;
    end else begin
      window_valid <= win_close;
      if (state_q == IDLE) begin
        win_cnt_q <= '0;
        if (enable) base_q <= total_energy_pj;
      end else if (!enable) begin
        win_cnt_q <= '0;
      end else if (win_close) begin
        win_cnt_q        <= '0;
        base_q           <= total_energy_pj;
        window_energy_pj <= delta_sat;
        over_budget      <= delta_sat > budget_hi_pj;
      end else begin
        win_cnt_q <= win_cnt_q + 1'b1;
      end
    end
  end

  // Streaks, PLL handshake, committed level/frequency and the error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_streak_q  <= '0;
      lo_streak_q  <= '0;
      target_q     <= LW'(RESET_LEVEL);
      tmo_cnt_q    <= '0;
      pll_req      <= 1'b0;
      pll_freq_mhz <= '0;
      level        <= LW'(RESET_LEVEL);
      freq_mhz     <= freq_of(LW'(RESET_LEVEL));
      timeout_err  <= 1'b0;
    end else begin
      // A timeout on the same edge as err_clr must leave the flag set.
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      if (!enable) begin
        pll_req     <= 1'b0;
        hi_streak_q <= '0;
        lo_streak_q <= '0;
        tmo_cnt_q   <= '0;
      end else if (start_req) begin
        pll_req      <= 1'b1;
        pll_freq_mhz <= freq_of(target_d);
        target_q     <= target_d;
        tmo_cnt_q    <= '0;
        hi_streak_q  <= hi_streak_d;
        lo_streak_q  <= lo_streak_d;
      end else if (eval) begin
        hi_streak_q <= hi_streak_d;
        lo_streak_q <= lo_streak_d;
      end else if (state_q == REQ) begin
        if (ack_take) begin
          level       <= target_q;
          freq_mhz    <= freq_of(target_q);
          pll_req     <= 1'b0;
          hi_streak_q <= '0;
          lo_streak_q <= '0;
        end else if (timeout_hit) begin
          pll_req     <= 1'b0;
          hi_streak_q <= '0;
          lo_streak_q <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef GOV_STATS_EN
  // Saturating counts of completed down (throttle) and up (boost) changes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      throttle_cnt <= '0;
      boost_cnt    <= '0;
    end else if (ack_take) begin
      if (target_q < level) begin
        if (throttle_cnt != 16'hFFFF) throttle_cnt <= throttle_cnt + 1'b1;
      end else begin
        if (boost_cnt != 16'hFFFF) boost_cnt <= boost_cnt + 1'b1;
      end
    end
  end
`else
  assign throttle_cnt = '0;
  assign boost_cnt    = '0;
`endif

endmodule

// File: tb/tb_energy_window_governor.sv
// Directed self-checking bench for energy_window_governor.
// Setup: WINDOW_CYCLES=16, HYST_WINDOWS=2, ACK_TIMEOUT=8, default table, RESET_LEVEL=3.
// The bench computes every expected value by hand from the window arithmetic.
module tb_energy_window_governor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [63:0] total_energy_pj;
  logic [31:0] budget_hi_pj;
  logic [31:0] budget_lo_pj;
  logic        pll_req;
  logic [15:0] pll_freq_mhz;
  logic        pll_ack;
  logic [15:0] freq_mhz;
  logic [1:0]  level;
  logic [31:0] window_energy_pj;
  logic        window_valid;
  logic        over_budget;
  logic        timeout_err;
  logic        err_clr;
  logic [15:0] throttle_cnt;
  logic [15:0] boost_cnt;

  logic [63:0] inc;
  int          tests_run    = 0;
  int          tests_failed = 0;

  energy_window_governor #(
    .WINDOW_CYCLES(16),
    .NUM_LEVELS   (4),
    .FREQ_TABLE   ({16'd400, 16'd250, 16'd200, 16'd100}),
    .RESET_LEVEL  (3),
    .HYST_WINDOWS (2),
    .ACK_TIMEOUT  (8)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .total_energy_pj (total_energy_pj),
    .budget_hi_pj    (budget_hi_pj),
    .budget_lo_pj    (budget_lo_pj),
    .pll_req         (pll_req),
    .pll_freq_mhz    (pll_freq_mhz),
    .pll_ack         (pll_ack),
    .freq_mhz        (freq_mhz),
    .level           (level),
    .window_energy_pj(window_energy_pj),
    .window_valid    (window_valid),
    .over_budget     (over_budget),
    .timeout_err     (timeout_err),
    .err_clr         (err_clr),
    .throttle_cnt    (throttle_cnt),
    .boost_cnt       (boost_cnt)
  );

  always #5 clk = ~clk;

  // One clock: sample point is 1 time unit after the edge, then the energy total advances.
  task automatic tick();
    @(posedge clk);
    #1;
    total_energy_pj = total_energy_pj + inc;
  endtask

  // Drop enable for one edge (back to IDLE), then restart with a new start total and slope.
  task automatic restart(input logic [63:0] start, input logic [63:0] step);
    enable  = 1'b0;
    pll_ack = 1'b0;
    tick();
    total_energy_pj = start;
    inc             = step;
    enable          = 1'b1;
  endtask

  // Tick until pll_req rises or the budget runs out; n is the number of ticks taken.
  task automatic wait_req(input int budget, output int n);
    n = 0;
    while (!pll_req && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; pll_ack = 1'b0; err_clr = 1'b0;
    total_energy_pj = '0; inc = '0; budget_hi_pj = 32'd3000; budget_lo_pj = 32'd500;
    #12;
    tests_run++;
    if (level !== 2'd3 || freq_mhz !== 16'd400) begin
      tests_failed++;
      $display("FAIL reset_level: level=%0d freq=%0d, want 3 and 400", level, freq_mhz);
    end
    tests_run++;
    if (pll_req !== 1'b0 || pll_freq_mhz !== 16'd0 || window_energy_pj !== 32'd0 ||
        window_valid !== 1'b0 || over_budget !== 1'b0 || timeout_err !== 1'b0 ||
        throttle_cnt !== 16'd0 || boost_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: req=%0b pf=%0d we=%0d wv=%0b ob=%0b te=%0b tc=%0d bc=%0d, want all 0",
               pll_req, pll_freq_mhz, window_energy_pj, window_valid, over_budget, timeout_err,
               throttle_cnt, boost_cnt);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    int held;
    restart(64'd0, 64'd200);
    wait_req(64, n);
    tests_run++;
    if (pll_req !== 1'b1 || n !== 34 || pll_freq_mhz !== 16'd250) begin
      tests_failed++;
      $display("FAIL timeout_req: req=%0b cycles=%0d pf=%0d, want 1, 34, 250", pll_req, n, pll_freq_mhz);
    end
    held = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (pll_req === 1'b1) held++;
    end
    tests_run++;
    if (held !== 7) begin
      tests_failed++;
      $display("FAIL timeout_hold: req high %0d of 7 cycles, want 7", held);
    end
    tick();
    tests_run++;
    if (pll_req !== 1'b0 || timeout_err !== 1'b1 || freq_mhz !== 16'd400 || level !== 2'd3) begin
      tests_failed++;
      $display("FAIL timeout_fire: req=%0b te=%0b freq=%0d level=%0d, want 0, 1, 400, 3",
               pll_req, timeout_err, freq_mhz, level);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests_run++;
    if (timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clear: te=%0b, want 0", timeout_err);
    end
  endtask

  task automatic test_throttle();
    int n;
    restart(64'd1000, 64'd200);
    wait_req(64, n);
    tests_run++;
    if (pll_req !== 1'b1 || n !== 34 || pll_freq_mhz !== 16'd250) begin
      tests_failed++;
      $display("FAIL throttle_req: req=%0b cycles=%0d pf=%0d, want 1, 34, 250", pll_req, n, pll_freq_mhz);
    end
    tests_run++;
    if (window_energy_pj !== 32'd3200 || over_budget !== 1'b1) begin
      tests_failed++;
      $display("FAIL throttle_window: we=%0d ob=%0b, want 3200 and 1", window_energy_pj, over_budget);
    end
    tick(); tick(); tick();
    tests_run++;
    if (pll_req !== 1'b1 || pll_freq_mhz !== 16'd250 || freq_mhz !== 16'd400) begin
      tests_failed++;
      $display("FAIL throttle_hold: req=%0b pf=%0d freq=%0d, want 1, 250, 400", pll_req, pll_freq_mhz, freq_mhz);
    end
    pll_ack = 1'b1;
    tick();
    pll_ack = 1'b0;
    tests_run++;
    if (pll_req !== 1'b0 || freq_mhz !== 16'd250 || level !== 2'd2) begin
      tests_failed++;
      $display("FAIL throttle_ack: req=%0b freq=%0d level=%0d, want 0, 250, 2", pll_req, freq_mhz, level);
    end
  endtask

  // Two more throttles to level 0, then over-budget windows at the floor must not request.
  task automatic test_floor();
    int          n;
    int          reqs;
    logic [15:0] exp_f [2];
    exp_f[0] = 16'd200;
    exp_f[1] = 16'd100;
    for (int k = 0; k < 2; k++) begin
      restart(64'd0, 64'd200);
      wait_req(64, n);
      pll_ack = 1'b1;
      tick();
      pll_ack = 1'b0;
      tests_run++;
      if (n !== 34 || level !== 2'(1 - k) || freq_mhz !== exp_f[k]) begin
        tests_failed++;
        $display("FAIL floor_step%0d: cycles=%0d level=%0d freq=%0d, want 34, %0d, %0d",
                 k, n, level, freq_mhz, 1 - k, exp_f[k]);
      end
    end
    restart(64'd0, 64'd200);
    reqs = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (pll_req === 1'b1) reqs++;
    end
    tests_run++;
    if (reqs !== 0 || level !== 2'd0 || freq_mhz !== 16'd100 || over_budget !== 1'b1) begin
      tests_failed++;
      $display("FAIL floor_no_req: req cycles=%0d level=%0d freq=%0d ob=%0b, want 0, 0, 100, 1",
               reqs, level, freq_mhz, over_budget);
    end
  endtask

  task automatic test_boost();
    int          n;
    logic [15:0] exp_thr;
    logic [15:0] exp_bst;
    restart(64'd0, 64'd10);
    wait_req(64, n);
    tests_run++;
    if (pll_req !== 1'b1 || n !== 34 || pll_freq_mhz !== 16'd200 ||
        window_energy_pj !== 32'd160 || over_budget !== 1'b0) begin
      tests_failed++;
      $display("FAIL boost_req: req=%0b cycles=%0d pf=%0d we=%0d ob=%0b, want 1, 34, 200, 160, 0",
               pll_req, n, pll_freq_mhz, window_energy_pj, over_budget);
    end
    pll_ack = 1'b1;
    tick();
    pll_ack = 1'b0;
    tests_run++;
    if (level !== 2'd1 || freq_mhz !== 16'd200 || pll_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL boost_ack: level=%0d freq=%0d req=%0b, want 1, 200, 0", level, freq_mhz, pll_req);
    end
`ifdef GOV_STATS_EN
    exp_thr = 16'd3;
    exp_bst = 16'd1;
`else
    exp_thr = 16'd0;
    exp_bst = 16'd0;
`endif
    tests_run++;
    if (throttle_cnt !== exp_thr || boost_cnt !== exp_bst) begin
      tests_failed++;
      $display("FAIL stats: throttle=%0d boost=%0d, want %0d and %0d", throttle_cnt, boost_cnt, exp_thr, exp_bst);
    end
  endtask

  // Alternate windows of 3200 and 1000 pJ: streaks never reach 2.
  task automatic test_hysteresis();
    int          reqs;
    int          pulses;
    int          bad_pos;
    int          bad_val;
    int          w;
    int          p;
    int          m;
    logic [31:0] exp_e;
    restart(64'd0, 64'd200);
    reqs = 0; pulses = 0; bad_pos = 0; bad_val = 0;
    for (int j = 1; j <= 97; j++) begin
      w = (j - 1) / 16;
      p = (j - 1) % 16;
      if (w % 2 == 0) inc = 64'd200;
      else            inc = (p == 15) ? 64'd70 : 64'd62;
      tick();
      if (pll_req === 1'b1) reqs++;
      if (window_valid === 1'b1) begin
        pulses++;
        if (j % 16 != 1 || j == 1) bad_pos++;
        m     = (j - 1) / 16;
        exp_e = ((m - 1) % 2 == 0) ? 32'd3200 : 32'd1000;
        if (window_energy_pj !== exp_e || over_budget !== ((m - 1) % 2 == 0)) bad_val++;
      end
    end
    tests_run++;
    if (reqs !== 0) begin
      tests_failed++;
      $display("FAIL hyst_no_req: req high for %0d cycles, want 0", reqs);
    end
    tests_run++;
    if (pulses !== 6 || bad_pos !== 0 || bad_val !== 0) begin
      tests_failed++;
      $display("FAIL hyst_windows: pulses=%0d misplaced=%0d wrong_value=%0d, want 6, 0, 0",
               pulses, bad_pos, bad_val);
    end
  endtask

  task automatic test_wrap_sat();
    restart(64'hFFFF_FFFF_FFFF_FF9C, 64'd200);
    for (int i = 0; i < 16; i++) tick();
    tests_run++;
    if (window_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_early_valid: wv=%0b, want 0", window_valid);
    end
    tick();
    tests_run++;
    if (window_valid !== 1'b1 || window_energy_pj !== 32'd3200) begin
      tests_failed++;
      $display("FAIL wrap_energy: wv=%0b we=%0d, want 1 and 3200", window_valid, window_energy_pj);
    end
    tick();
    tests_run++;
    if (window_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_pulse_width: wv=%0b, want 0", window_valid);
    end
    restart(64'd0, 64'h0000_0000_4000_0000);
    for (int i = 0; i < 17; i++) tick();
    tests_run++;
    if (window_valid !== 1'b1 || window_energy_pj !== 32'hFFFF_FFFF || over_budget !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_energy: wv=%0b we=%h ob=%0b, want 1, ffffffff, 1", window_valid, window_energy_pj, over_budget);
    end
  endtask

  task automatic test_abort();
    int n;
    int activity;
    restart(64'd0, 64'd200);
    wait_req(64, n);
    tests_run++;
    if (pll_req !== 1'b1 || n !== 34 || pll_freq_mhz !== 16'd100) begin
      tests_failed++;
      $display("FAIL abort_req: req=%0b cycles=%0d pf=%0d, want 1, 34, 100", pll_req, n, pll_freq_mhz);
    end
    enable = 1'b0;
    tick();
    tests_run++;
    if (pll_req !== 1'b0 || level !== 2'd1 || freq_mhz !== 16'd200) begin
      tests_failed++;
      $display("FAIL abort_drop: req=%0b level=%0d freq=%0d, want 0, 1, 200", pll_req, level, freq_mhz);
    end
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_req === 1'b1 || window_valid === 1'b1) activity++;
    end
    tests_run++;
    if (activity !== 0) begin
      tests_failed++;
      $display("FAIL abort_idle: %0d active cycles while disabled, want 0", activity);
    end
  endtask

  task automatic test_async_reset();
    int n;
    restart(64'd0, 64'd200);
    wait_req(64, n);
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (n !== 34 || level !== 2'd3 || freq_mhz !== 16'd400 || pll_req !== 1'b0 ||
        pll_freq_mhz !== 16'd0 || window_energy_pj !== 32'd0 || window_valid !== 1'b0 ||
        over_budget !== 1'b0 || timeout_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: cycles=%0d level=%0d freq=%0d req=%0b pf=%0d we=%0d wv=%0b ob=%0b te=%0b, want 34, 3, 400, 0, 0, 0, 0, 0, 0",
               n, level, freq_mhz, pll_req, pll_freq_mhz, window_energy_pj, window_valid, over_budget, timeout_err);
    end
    enable  = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_throttle();
    test_floor();
    test_boost();
    test_hysteresis();
    test_wrap_sat();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
